// File: rtl/lsu_pkg.sv
// lsu_pkg: access-size encodings and FSM states shared by the load/store unit.
package lsu_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   typedef enum logic [2:0] {IDLE, RD, MOD, WR, RESP} state_e;
endpackage

// File: rtl/lsu_lane_mux.sv
// lsu_lane_mux: big-endian lane extract with sign/zero-extension and lane merge.
// Size 11 falls through to the word path.
module lsu_lane_mux
   import lsu_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        uns_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] rword_i,
   input  logic [31:0] mword_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] ext_o,
   output logic [31:0] merged_o
);
   logic [4:0]  sh;
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      // byte k sits at bit 8*(3-k); ~off equals 3-off for two bits
      sh = {~off_i, 3'b000};
      b = 8'(rword_i >> sh);
      h = off_i[1] ? rword_i[15:0] : rword_i[31:16];
      ext_o = (size_i == SZ_BYTE) ? {{24{~uns_i & b[7]}}, b} :
              (size_i == SZ_HALF) ? {{16{~uns_i & h[15]}}, h} : rword_i;
      merged_o = (size_i == SZ_BYTE) ? ((mword_i & ~(32'hFF << sh)) | (32'(wdata_i[7:0]) << sh)) :
                 (size_i == SZ_HALF) ? (off_i[1] ? {mword_i[31:16], wdata_i[15:0]} : {wdata_i[15:0], mword_i[15:0]}) :
                 wdata_i;
   end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store FSM with read-modify-write for sub-word stores.
// LSU_ALIGN_CHECK_EN enables misalignment and illegal-size errors; otherwise only range errors.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEMORY_SIZE = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_write,
   input  logic [31:0] mem_rdata
);
   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, word_q, word_d, rdata_q, rdata_d;
   logic [1:0]  size_q, size_d;
   logic        we_q, we_d, uns_q, uns_d, err_q, err_d;
   logic [31:0] ext, merged;
   logic        oor, err_in;

   assign oor = {addr[31:2], 2'b00} > 32'(MEMORY_SIZE - 4);
`ifdef LSU_ALIGN_CHECK_EN
   assign err_in = oor | (size == 2'b11) | ((size == SZ_HALF) & addr[0]) | ((size == SZ_WORD) & (addr[1:0] != 2'b00));
`else
   assign err_in = oor;
`endif

   lsu_lane_mux u_mux (
      .size_i  (size_q),
      .uns_i   (uns_q),
      .off_i   (addr_q[1:0]),
      .rword_i (mem_rdata),
      .mword_i (word_q),
      .wdata_i (wdata_q),
      .ext_o   (ext),
      .merged_o(merged)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      word_d  = word_q;
      rdata_d = rdata_q;
      size_d  = size_q;
      we_d    = we_q;
      uns_d   = uns_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (req) begin
            addr_d  = addr;
            size_d  = size;
            we_d    = we;
            uns_d   = uns;
            wdata_d = wdata;
            word_d  = wdata;
            err_d   = err_in;
            rdata_d = err_in ? 32'h0 : rdata_q;
            state_d = err_in ? RESP : (we & size[1]) ? WR : RD;
         end
         RD: begin
            word_d  = mem_rdata;
            rdata_d = we_q ? rdata_q : ext;
            state_d = we_q ? MOD : RESP;
         end
         MOD: begin
            word_d  = merged;
            state_d = WR;
         end
         WR:      state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         word_q  <= '0;
         rdata_q <= '0;
         size_q  <= '0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         word_q  <= word_d;
         rdata_q <= rdata_d;
         size_q  <= size_d;
         we_q    <= we_d;
         uns_q   <= uns_d;
         err_q   <= err_d;
      end
   end

   assign busy      = state_q != IDLE;
   assign done      = state_q == RESP;
   assign err       = done & err_q;
   assign rdata     = rdata_q;
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_wdata = word_q;
   assign mem_write = (state_q == WR) & ~rst;
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEMORY_SIZE, 64, data memory size in bytes; word-aligned addresses above MEMORY_SIZE-4 are out of range.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req  input  1  access request, sampled only in IDLE.
REQ-005 Port: we  input  1  1 = store, 0 = load.
REQ-006 Port: size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 Port: uns  input  1  load zero-extension when 1, sign-extension when 0.
REQ-008 Port: addr  input  32  byte address.
REQ-009 Port: wdata  input  32  store data, right-justified.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: done  output  1  one-cycle completion pulse.
REQ-012 Port: err  output  1  valid with done; access was misaligned, illegal or out of range.
REQ-013 Port: rdata  output  32  load result, held until the next done.
REQ-014 Port: mem_addr  output  32  word-aligned memory address (bits 1:0 always 0).
REQ-015 Port: mem_wdata  output  32  word written to memory.
REQ-016 Port: mem_write  output  1  memory write strobe; memory commits the word on the same posedge.
REQ-017 Port: mem_rdata  input  32  combinational big-endian memory read data at mem_addr.

Function
REQ-018 The FSM SHALL have states IDLE, RD, MOD, WR and RESP.
REQ-019 IDLE: req=1 latches addr, size, we, uns and wdata; the next state is RESP with err=1 on an error, RD for loads and sub-word stores, and WR for word stores.
REQ-020 An error is any of: size=11; halfword with addr[0]=1; word with addr[1:0]!=0; (addr & ~3) > MEMORY_SIZE-4. An errored access SHALL perform no memory write and SHALL set rdata=0.
REQ-021 RD: mem_addr = latched addr & ~3; for loads, the selected lane SHALL be extended into rdata and the next state SHALL be RESP; for sub-word stores, mem_rdata SHALL be captured and the next state SHALL be MOD.
REQ-022 Lane order is big-endian: byte k=addr[1:0] occupies bits [31-8k:24-8k]; halfword at addr[1]=0 occupies bits 31:16, and at addr[1]=1 occupies bits 15:0.
REQ-023 MOD: the captured word SHALL be merged with wdata[7:0] or wdata[15:0] in the selected lane only, then the FSM SHALL go to WR.
REQ-024 WR: mem_write=1 for exactly one cycle, with mem_wdata = merged word (sub-word) or wdata (word); the next state SHALL be RESP.
REQ-025 RESP: done=1 and err valid for one cycle; the next state SHALL be IDLE.
REQ-026 Latency from the req edge to done: load 2 cycles, word store 2 cycles, sub-word store 4 cycles, error 1 cycle.
REQ-027 req while busy SHALL be ignored and not queued; req in the same cycle as done SHALL be ignored.
REQ-028 mem_write SHALL be 0 in every state except WR, and SHALL be 0 whenever rst=1.

Reset
REQ-029 rst=1 at posedge SHALL force IDLE with done=0, err=0, rdata=0, mem_addr=0 and mem_wdata=0, and SHALL take priority over req.
REQ-030 rst asserted in any state, including mid read-modify-write, SHALL abort the access with no done and no memory write.

Configuration
REQ-031 With LSU_ALIGN_CHECK_EN defined, the misalignment and illegal-size checks of REQ-020 SHALL be active.
REQ-032 With LSU_ALIGN_CHECK_EN undefined, low address bits not meaningful for the access size SHALL be ignored, size=11 SHALL be treated as word, err SHALL be raised only for out-of-range accesses, and the extra check logic SHALL be absent.

Structure
REQ-033 Package lsu_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-034 The combinational sub-module lsu_lane_mux SHALL perform lane extract with sign/zero-extension and lane merge; the FSM and registers SHALL stay in load_store_unit.

Verification
REQ-035 Memory holds 0x11223380 at byte 8; a byte load at addr 11 with uns=0 -> done 2 cycles after req, rdata=0xFFFFFF80, err=0.
REQ-036 Memory holds 0xAABBCCDD at byte 4; a byte store of wdata=0x55 at addr 6 -> one mem_write with mem_wdata=0xAABB55DD, done 4 cycles after req.
REQ-037 A word load at addr 2 with LSU_ALIGN_CHECK_EN defined -> done 1 cycle after req, err=1, rdata=0, no mem_write; without the macro -> word at byte 0 is returned with err=0.
REQ-038 A word store at addr 64 with MEMORY_SIZE=64 -> err=1 and mem_write never asserted.
REQ-039 rst pulsed during MOD of a halfword store -> IDLE on the next cycle, no mem_write, no done; a following req completes normally.
REQ-040 req held high for 6 cycles with a word load at addr 0 -> exactly two accesses, each with a single done pulse.
